// File: rtl/axis_i2c_pkg.sv
// Shared definitions for the AXI-Stream I2C engine and the requester arbiter in front of it.
// Request word layout: [15:8] write data, [7:0] 7-bit address plus R/W flag in bit 0.
package axis_i2c_pkg;

    localparam int AXIS_DATA_WIDTH = 16;
    localparam int I2C_DATA_WIDTH  = 8;
    localparam int I2C_RW_BIT      = 0;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } arb_state_t;

    function automatic logic is_read(input logic [AXIS_DATA_WIDTH-1:0] tdata);
        return tdata[I2C_RW_BIT] == READ;
    endfunction

endpackage

// File: rtl/axis_i2c_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, wrapping
// around NUM_REQ.
module axis_i2c_rr_pick
    import axis_i2c_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [REQ_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [REQ_W-1:0]   idx_o,
    output logic               any_o
);

    logic [REQ_W-1:0] cand;

    // NOTE: every output and temporary gets a default before the search loop, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = REQ_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_i2c_arbiter.sv
// Round-robin sequencer sharing one axis_i2c_slave engine between NUM_REQ requesters.
// Ownership is held from capture until the engine is idle again, or until the watchdog fires.
module axis_i2c_arbiter
    import axis_i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 arst_i,
    input  logic [NUM_REQ-1:0]                   s_tvalid_i,
    output logic [NUM_REQ-1:0]                   s_tready_o,
    input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0]   s_tdata_i,
    output logic                                 m_tvalid_o,
    input  logic                                 m_tready_i,
    output logic [AXIS_DATA_WIDTH-1:0]           m_tdata_o,
    input  logic [I2C_DATA_WIDTH-1:0]            i2c_rdata_i,
    input  logic                                 rvalid_i,
    output logic [I2C_DATA_WIDTH-1:0]            rdata_o,
    output logic [NUM_REQ-1:0]                   rvalid_o,
    output logic [NUM_REQ-1:0]                   grant_o,
    output logic                                 timeout_o
);

    localparam int REQ_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REQ_W-1:0] IDX_LAST = REQ_W'(NUM_REQ - 1);

    arb_state_t                 state_q, state_n;
    logic [NUM_REQ-1:0]         grant_q, grant_n;
    logic [REQ_W-1:0]           owner_q, owner_n;
    logic [REQ_W-1:0]           rr_ptr_q, rr_ptr_n;
    logic [CNT_W-1:0]           cnt_q, cnt_n;
    logic                       timeout_q, timeout_n;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_n;
    logic [I2C_DATA_WIDTH-1:0]  rdata_q, rdata_n;

    logic [AXIS_DATA_WIDTH-1:0] req_data [NUM_REQ];
    logic [NUM_REQ-1:0]         pick_onehot;
    logic [REQ_W-1:0]           pick_idx;
    logic                       pick_any;
    logic [REQ_W-1:0]           ptr_after_owner;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data[g] = s_tdata_i[g*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    end

    axis_i2c_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (s_tvalid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_onehot),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign ptr_after_owner = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_n    = state_q;
        grant_n    = grant_q;
        owner_n    = owner_q;
        rr_ptr_n   = rr_ptr_q;
        cnt_n      = cnt_q;
        timeout_n  = 1'b0;
        tdata_n    = tdata_q;
        rdata_n    = rdata_q;
        s_tready_o = '0;
        m_tvalid_o = 1'b0;
        rvalid_o   = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    s_tready_o = pick_onehot;
                    tdata_n    = req_data[pick_idx];
                    grant_n    = pick_onehot;
                    owner_n    = pick_idx;
                    state_n    = ISSUE;
                end
            end

            ISSUE: begin
                m_tvalid_o = 1'b1;
                if (m_tready_i) begin
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end

            BUSY: begin
                if (rvalid_i) begin
                    rvalid_o = grant_q;
                    rdata_n  = i2c_rdata_i;
                end
                // The engine still shows tready on its first BUSY cycle, so only a count of
                // one or more can signal completion; completion outranks the watchdog.
                if (cnt_q != '0 && m_tready_i) begin
                    grant_n  = '0;
                    rr_ptr_n = ptr_after_owner;
                    state_n  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    grant_n   = '0;
                    rr_ptr_n  = ptr_after_owner;
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            tdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            owner_q   <= owner_n;
            rr_ptr_q  <= rr_ptr_n;
            cnt_q     <= cnt_n;
            timeout_q <= timeout_n;
            tdata_q   <= tdata_n;
            rdata_q   <= rdata_n;
        end
    end

    assign grant_o   = grant_q;
    assign m_tdata_o = tdata_q;
    assign rdata_o   = rdata_q;
    assign timeout_o = timeout_q;

endmodule
